// File: rtl/mdio_scheduler_if.sv
// Bus between the MDIO scheduler and the MDIO management controller.
// The scheduler drives start/addr_mode/data; the controller answers with busy and read data.
interface mdio_scheduler_if;
    logic        ctrl_start_o;
    logic [10:0] ctrl_addr_mode_o;
    logic [15:0] ctrl_data_o;
    logic [15:0] ctrl_data_i;
    logic        ctrl_busy_i;

    modport master (
        output ctrl_start_o,
        output ctrl_addr_mode_o,
        output ctrl_data_o,
        input  ctrl_data_i,
        input  ctrl_busy_i
    );

    modport slave (
        input  ctrl_start_o,
        input  ctrl_addr_mode_o,
        input  ctrl_data_o,
        output ctrl_data_i,
        output ctrl_busy_i
    );
endinterface

// File: rtl/mdio_scheduler.sv
// Sequences the MDIO controller: PHY reset/init, periodic BMSR link polling,
// and fair sharing of the controller between the poller and one host port.
module mdio_scheduler #(
    parameter logic [4:0]  PHY_ADDR     = 5'h01,
    parameter logic [15:0] INIT_BMCR    = 16'h8000,
    parameter logic [7:0]  INIT_TIMEOUT = 8'd255,
    parameter logic [31:0] POLL_PERIOD  = 32'd1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_req_i,
    input  logic                   host_we_i,
    input  logic [4:0]             host_reg_i,
    input  logic [15:0]            host_wdata_i,
    output logic                   host_ack_o,
    output logic [15:0]            host_rdata_o,
    output logic                   link_up_o,
    output logic                   init_done_o,
    output logic                   init_err_o,
    mdio_scheduler_if.master       ctrl
);

    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_INIT_RD,
        ST_RUN,
        ST_ISSUE,
        ST_WAIT_LAT,
        ST_WAIT_BUSY
    } state_t;

    typedef enum logic [1:0] {
        TX_INIT_WR,
        TX_INIT_RD,
        TX_HOST,
        TX_POLL
    } txn_t;

    state_t      state;
    txn_t        txn;
    logic [4:0]  txn_reg;
    logic        txn_we;
    logic [15:0] txn_wdata;
    logic [31:0] poll_timer;
    logic        poll_pend;
    logic        last_grant_poll;
    logic [7:0]  init_count;

    logic        host_ok;
    logic        grant_host;
    logic        grant_poll;
    logic        poll_expire;

    // The host request is ignored during the ack cycle, so a held request is
    // never granted twice; on contention the side not served last wins.
    always_comb begin
        host_ok     = host_req_i && !host_ack_o;
        poll_expire = init_done_o && (poll_timer == 32'd0);
        grant_host  = 1'b0;
        grant_poll  = 1'b0;
        if (host_ok && poll_pend) begin
            grant_host = last_grant_poll;
            grant_poll = !last_grant_poll;
        end else begin
            grant_host = host_ok;
            grant_poll = poll_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_timer <= POLL_PERIOD - 32'd1;
        end else if (init_done_o) begin
            if (poll_timer == 32'd0) begin
                poll_timer <= POLL_PERIOD - 32'd1;
            end else begin
                poll_timer <= poll_timer - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_INIT_WR;
            txn                   <= TX_INIT_WR;
            txn_reg               <= 5'd0;
            txn_we                <= 1'b0;
            txn_wdata             <= 16'd0;
            poll_pend             <= 1'b0;
            last_grant_poll       <= 1'b1;
            init_count            <= 8'd0;
            host_ack_o            <= 1'b0;
            host_rdata_o          <= 16'd0;
            link_up_o             <= 1'b0;
            init_done_o           <= 1'b0;
            init_err_o            <= 1'b0;
            ctrl.ctrl_start_o     <= 1'b0;
            ctrl.ctrl_addr_mode_o <= 11'd0;
            ctrl.ctrl_data_o      <= 16'd0;
        end else begin
            host_ack_o        <= 1'b0;
            ctrl.ctrl_start_o <= 1'b0;
            case (state)
                ST_INIT_WR: begin
                    txn       <= TX_INIT_WR;
                    txn_reg   <= 5'd0;
                    txn_we    <= 1'b1;
                    txn_wdata <= INIT_BMCR;
                    state     <= ST_ISSUE;
                end
                ST_INIT_RD: begin
                    txn     <= TX_INIT_RD;
                    txn_reg <= 5'd0;
                    txn_we  <= 1'b0;
                    state   <= ST_ISSUE;
                end
                ST_RUN: begin
                    if (grant_host) begin
                        txn             <= TX_HOST;
                        txn_reg         <= host_reg_i;
                        txn_we          <= host_we_i;
                        txn_wdata       <= host_wdata_i;
                        last_grant_poll <= 1'b0;
                        state           <= ST_ISSUE;
                    end else if (grant_poll) begin
                        txn             <= TX_POLL;
                        txn_reg         <= 5'd1;
                        txn_we          <= 1'b0;
                        last_grant_poll <= 1'b1;
                        poll_pend       <= 1'b0;
                        state           <= ST_ISSUE;
                    end
                end
                // Waiting for idle here also covers a controller still busy
                // with a transaction that was cut off by reset.
                ST_ISSUE: begin
                    if (!ctrl.ctrl_busy_i) begin
                        ctrl.ctrl_start_o     <= 1'b1;
                        ctrl.ctrl_addr_mode_o <= {PHY_ADDR, txn_reg, txn_we};
                        if (txn_we) begin
                            ctrl.ctrl_data_o <= txn_wdata;
                        end
                        state <= ST_WAIT_LAT;
                    end
                end
                ST_WAIT_LAT: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!ctrl.ctrl_busy_i) begin
                        state <= ST_RUN;
                        case (txn)
                            TX_INIT_WR: begin
                                state <= ST_INIT_RD;
                            end
                            TX_INIT_RD: begin
                                init_count <= init_count + 8'd1;
                                if (!ctrl.ctrl_data_i[15]) begin
                                    init_done_o <= 1'b1;
                                end else if (init_count + 8'd1 == INIT_TIMEOUT) begin
                                    init_done_o <= 1'b1;
                                    init_err_o  <= 1'b1;
                                end else begin
                                    state <= ST_INIT_RD;
                                end
                            end
                            TX_HOST: begin
                                host_ack_o <= 1'b1;
                                if (!txn_we) begin
                                    host_rdata_o <= ctrl.ctrl_data_i;
                                end
                            end
                            TX_POLL: begin
                                link_up_o <= ctrl.ctrl_data_i[2];
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_INIT_WR;
                end
            endcase
            // A timer expiry wins over a same-cycle grant; only one poll is ever pending.
            if (poll_expire) begin
                poll_pend <= 1'b1;
            end
        end
    end

endmodule
